// File: rtl/rf_write_sequencer.sv
// rtl/rf_write_sequencer.sv - round-robin two-port write sequencer driving register-file DIN and one-hot LOAD strobes
module rf_write_sequencer #(
  parameter int RF_DEPTH         = 256,
  parameter int LC_RF_DATA_WIDTH = 24,
  parameter int LC_RF_ADDR_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic                        REQ0,
  input  logic [LC_RF_ADDR_WIDTH-1:0] ADDR0,
  input  logic [LC_RF_DATA_WIDTH-1:0] DATA0,
  output logic                        ACK0,
  input  logic                        REQ1,
  input  logic [LC_RF_ADDR_WIDTH-1:0] ADDR1,
  input  logic [LC_RF_DATA_WIDTH-1:0] DATA1,
  output logic                        ACK1,
  output logic [LC_RF_DATA_WIDTH-1:0] DIN,
  output logic [RF_DEPTH-1:0]         LOAD,
  output logic                        BUSY,
  output logic                        ERR
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [RF_DEPTH-1:0] LOAD_ONE = RF_DEPTH'(1);

  state_t                      state_q, state_d;
  logic                        gnt_q, gnt_d;
  logic                        rr_q, rr_d;
  logic [LC_RF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LC_RF_DATA_WIDTH-1:0] data_q, data_d;
  logic [LC_RF_DATA_WIDTH-1:0] din_q, din_d;
  logic [RF_DEPTH-1:0]         load_q, load_d;
  logic                        ack0_q, ack0_d;
  logic                        ack1_q, ack1_d;
  logic                        err_q, err_d;
  logic                        busy_q, busy_d;
  logic                        req0_v, req1_v;
  logic                        addr_oor;

  assign addr_oor = (32'(addr_q) >= RF_DEPTH);

  // A port whose ACK is showing this cycle is still releasing REQ, so it is not re-granted yet.
  assign req0_v = REQ0 & ~ack0_q;
  assign req1_v = REQ1 & ~ack1_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    din_d   = din_q;
    load_d  = '0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_v || req1_v) begin
          gnt_d   = (req0_v && req1_v) ? rr_q : req1_v;
          rr_d    = ~gnt_d;
          addr_d  = gnt_d ? ADDR1 : ADDR0;
          data_d  = gnt_d ? DATA1 : DATA0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        din_d   = data_q;
        state_d = STROBE;
      end
      STROBE: begin
        if (!addr_oor) begin
          load_d = LOAD_ONE << addr_q;
        end
        state_d = HOLD;
      end
      HOLD: begin
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        err_d   = addr_oor;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs lag the state by one edge, so BUSY also covers the ACK cycle.
    busy_d = (state_d != IDLE) || (state_q == HOLD);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      din_q   <= '0;
      load_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      din_q   <= din_d;
      load_q  <= load_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign DIN  = din_q;
  assign LOAD = load_q;
  assign ACK0 = ack0_q;
  assign ACK1 = ack1_q;
  assign ERR  = err_q;
  assign BUSY = busy_q;

endmodule

// File: doc/rf_write_sequencer.md
Name: rf_write_sequencer

Overview:
- Two-requester write controller for the layer-controller register file, which has per-entry edge-triggered LOAD strobes.
- Arbitrates round-robin between port 0 (MBus layer-controller write path) and port 1 (local/internal write path).
- Latches one address/data pair per grant and drives DIN and a single one-hot LOAD pulse with guaranteed setup and hold around the rising edge.
- Sits between the layer controller and the register file; it is the only driver of DIN/LOAD.

Parameters:
- RF_DEPTH, 256: number of register-file entries; width of LOAD.
- LC_RF_DATA_WIDTH, 24: register data width.
- LC_RF_ADDR_WIDTH, 8: request address width; must satisfy 2^LC_RF_ADDR_WIDTH >= RF_DEPTH.

Ports:
- CLK  input  1  system clock.
- RESETn  input  1  asynchronous active-low reset.
- REQ0  input  1  port-0 write request; held high until ACK0.
- ADDR0  input  LC_RF_ADDR_WIDTH  port-0 target entry.
- DATA0  input  LC_RF_DATA_WIDTH  port-0 write data.
- ACK0  output  1  one-cycle completion pulse, port 0.
- REQ1  input  1  port-1 write request.
- ADDR1  input  LC_RF_ADDR_WIDTH  port-1 target entry.
- DATA1  input  LC_RF_DATA_WIDTH  port-1 write data.
- ACK1  output  1  one-cycle completion pulse, port 1.
- DIN  output  LC_RF_DATA_WIDTH  register-file write data.
- LOAD  output  RF_DEPTH  one-hot per-entry load strobe; the register file captures on its rising edge.
- BUSY  output  1  high whenever the FSM is not in IDLE.
- ERR  output  1  pulses together with ACK when the request address is >= RF_DEPTH.

Behaviour:
- Clock and reset: one clock, CLK. RESETn is asynchronous and active-low. Every flop clears immediately on RESETn low.
- Reset values: DIN=0, LOAD=0, ACK0=ACK1=0, ERR=0, BUSY=0, FSM=IDLE, round-robin pointer=0 (port 0 preferred).
- Glitch-free LOAD: each LOAD bit is a direct flop output with no combinational decode after the flop. LOAD bits are edge clocks downstream, so glitch-free is mandatory.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if any REQ is high, grant, latch the granted ADDR/DATA into internal registers, then go to SETUP. Otherwise stay.
  - SETUP: DIN = latched data; LOAD all 0. Go to STROBE.
  - STROBE: LOAD[addr]=1 for exactly one cycle (all 0 if addr out of range). DIN is unchanged. Go to HOLD.
  - HOLD: LOAD all 0; DIN is unchanged. The granted ACK pulses high for this one cycle; ERR pulses here too if addr >= RF_DEPTH. Go to IDLE.
- Timing: a request sampled at edge N produces LOAD rising at edge N+2, LOAD falling and ACK high at edge N+3, and IDLE at N+4. Each write takes 4 cycles; the maximum throughput is one write per 4 cycles.
- DIN after a write: DIN holds its last value after HOLD until the next grant's SETUP. It is never changed in the same cycle LOAD rises or falls.
- Arbitration: with a single requester, that port wins. With both requesters, the port selected by the pointer wins. After every grant the pointer points to the non-granted port, so under sustained contention grants strictly alternate.
- Request sampling: requests are sampled only in IDLE. Request changes during SETUP/STROBE/HOLD are ignored. ADDR/DATA may change after the grant because they are latched.
- Requester protocol: the requester drops REQ in the cycle after ACK. If REQ is still high when the FSM returns to IDLE, it is treated as a new request.
- Out-of-range address: no LOAD bit asserts and the register-file contents are untouched. The cycle timing is identical to a normal write, and ACK and ERR both pulse.
- Reset mid-operation: a RESETn assertion during STROBE forces LOAD low asynchronously. The write is abandoned with no ACK. After release the FSM starts in IDLE.
- Address width: addresses are compared as unsigned LC_RF_ADDR_WIDTH-bit values. No wrap-around or truncation to RF_DEPTH is performed.

Test Plan:
- Single write: REQ0=1, ADDR0=0x05, DATA0=0xA5A5A5 sampled at edge 0 -> DIN=0xA5A5A5 after edge 1; LOAD=1<<5 only between edges 2 and 3; ACK0 high between edges 3 and 4; BUSY low after edge 4; register 5 reads 0xA5A5A5.
- Contention: REQ0 and REQ1 held high continuously from reset with ADDR0=1, ADDR1=2 -> grant order port0, port1, port0, port1; LOAD strobes on entries 1, 2, 1, 2 at 4-cycle spacing; ACKs alternate.
- Out of range with RF_DEPTH=200: REQ1 with ADDR1=0xC8 -> LOAD stays 0 throughout; ACK1 and ERR pulse together at edge 3; no register changes.
- Input change after grant: write ADDR0=0x10, DATA0=0x000001, then ADDR0/DATA0 changed to 0x11/0xFFFFFF in the SETUP cycle -> entry 0x10 gets 0x000001; entry 0x11 is unchanged.
- Reset mid-write: RESETn driven low while LOAD[3]=1 -> LOAD, DIN, BUSY and ACK all 0 immediately. After release, REQ0 to entry 3 completes normally with a fresh 4-cycle sequence.
- Glitch check: across 500 random writes, every LOAD bit shows exactly one rising edge per targeted write and none otherwise, and DIN is stable for at least one full cycle before and after each rising edge.
